regfile_scoreboard: RTL

//  Parametrised 2-read/1-write register file with a per-register pending-write scoreboard.

---
 rtl/regfile_scoreboard.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read/1-write register file with a per-register
// pending-write scoreboard for the decode stage.
//   - Reads are combinational; writes and count updates happen on posedge clk.
//   - rst is asynchronous and active-low.
//   - Optional macro WR_BYPASS_EN: same-cycle writeback data forwarding onto
//     the read ports, and busy flags that already account for a final writeback.
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int PCNT_W   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  output logic             rd_busy1,
  output logic             rd_busy2,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             rsv_full,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             flush,
  output logic             wb_err
);

  localparam logic [PCNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic [PCNT_W-1:0] cnt_q  [DEPTH];
  logic [PCNT_W-1:0] cnt_d  [DEPTH];
  logic              wb_err_q;
  logic              wb_err_d;

  logic [PCNT_W-1:0] rsv_cnt;
  logic [PCNT_W-1:0] wb_cnt;
  logic              wb_live;
  logic              rsv_inc;
  logic              wb_dec;

  // An address names a real, modifiable register: inside DEPTH and not the
  // hardwired zero register.
  function automatic logic addr_live(input logic [AW-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = (int'(a) < DEPTH);
    is_zero  = (ZERO_REG != 0) && (a == '0);
    return in_range && !is_zero;
  endfunction

  // Pending count of an address; dead addresses read as an idle register.
  function automatic logic [PCNT_W-1:0] cnt_at(input logic [AW-1:0] a);
    logic [PCNT_W-1:0] c;
    c = '0;
    if (addr_live(a)) begin
      c = cnt_q[a];
    end
    return c;
  endfunction

  // Stored data of an address; dead addresses read as zero.
  function automatic logic [WIDTH-1:0] data_at(input logic [AW-1:0] a);
    logic [WIDTH-1:0] d;
    d = '0;
    if (addr_live(a)) begin
      d = regs_q[a];
    end
    return d;
  endfunction

  // Decode of the reserve and writeback requests against current counts.
  always_comb begin
    rsv_cnt  = cnt_at(rsv_addr);
    wb_cnt   = cnt_at(wb_addr);
    rsv_full = addr_live(rsv_addr) && (rsv_cnt == CNT_MAX);
    wb_live  = wb_en && addr_live(wb_addr);
    // A reserve in a flush cycle is dropped, so it never increments.
    rsv_inc  = rsv_en && addr_live(rsv_addr) && !rsv_full && !flush;
    wb_dec   = wb_live && (wb_cnt != '0);
    // Underflow is only reported outside flush cycles.
    wb_err_d = wb_live && (wb_cnt == '0) && !flush;
  end

  // Next-state register data: only the writeback target changes.
  always_comb begin
    for (int unsigned r = 0; r < DEPTH; r++) begin
      regs_d[r] = regs_q[r];
      if (wb_live && (wb_addr == AW'(r))) begin
        regs_d[r] = wb_data;
      end
    end
  end

  // Next-state pending counts: flush clears all, otherwise +1 / -1 / hold.
  always_comb begin
    for (int unsigned r = 0; r < DEPTH; r++) begin
      logic inc;
      logic dec;
      inc      = rsv_inc && (rsv_addr == AW'(r));
      dec      = wb_dec && (wb_addr == AW'(r));
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + PCNT_W'(1);
      end else if (dec && !inc) begin
        cnt_d[r] = cnt_q[r] - PCNT_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      wb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      wb_err_q <= wb_err_d;
    end
  end

  // Read ports: stored data, optionally forwarded from a same-cycle writeback.
  always_comb begin
    rd_data1 = data_at(rd_addr1);
    rd_data2 = data_at(rd_addr2);
`ifdef WR_BYPASS_EN
    if (wb_live && (wb_addr == rd_addr1)) begin
      rd_data1 = wb_data;
    end
    if (wb_live && (wb_addr == rd_addr2)) begin
      rd_data2 = wb_data;
    end
`endif
  end

  // Busy flags: nonzero pending count, optionally net of this cycle's writeback.
  always_comb begin
    logic [PCNT_W-1:0] c1;
    logic [PCNT_W-1:0] c2;
    c1 = cnt_at(rd_addr1);
    c2 = cnt_at(rd_addr2);
`ifdef WR_BYPASS_EN
    if (wb_dec && (wb_addr == rd_addr1)) begin
      c1 = c1 - PCNT_W'(1);
    end
    if (wb_dec && (wb_addr == rd_addr2)) begin
      c2 = c2 - PCNT_W'(1);
    end
`endif
    rd_busy1 = (c1 != '0);
    rd_busy2 = (c2 != '0);
  end

  assign wb_err = wb_err_q;

endmodule
